multicycle_ctrl_rv32i: RTL
==========================

Name: multicycle_ctrl_rv32i

Overview:
Moore-style multi-cycle control unit for the RV32I core. It sequences fetch, decode, execute, memory and writeback across several cycles. It generates every datapath strobe, including the registered cu_immtype that steers the immediate selector. Memory accesses use a ready handshake with a watchdog, and illegal opcodes or memory timeouts park the core in a sticky TRAP state.

Parameters:
MEM_TIMEOUT, 16, maximum cycles a memory request may wait for mem_ready before faulting (legal range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0], taken from the instruction register
mem_ready  in  1  memory acknowledges the current read/write this cycle
cu_state  out  3  current FSM state, for debug
cu_pcwrite  out  1  PC register load enable
cu_irwrite  out  1  instruction register load enable
cu_immtype  out  3  immediate format: I=000, S=001, B=010, U=011, J=100
cu_alusrc  out  1  ALU operand B select: 0=rs2, 1=imm
cu_wbsel  out  2  writeback source: 00=ALU, 01=mem, 10=PC+4, 11=imm
cu_branch  out  1  PC load is conditional on the branch comparator
cu_regwrite  out  1  register file write enable
cu_memread  out  1  memory read request
cu_memwrite  out  1  memory write request
cu_iaddr_sel  out  1  memory address source: 1=PC (fetch), 0=ALU result
cu_trap  out  1  sticky fault flag
cu_cause  out  2  fault cause: 00=none, 01=illegal opcode, 10=fetch timeout, 11=data timeout

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-high. Reset forces state IDLE, clears the wait counter, sets cu_immtype=000, cu_cause=00, and drives all other outputs to 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Transitions:
  - IDLE -> FETCH unconditionally, one cycle after reset release.
  - FETCH: cu_memread=1, cu_iaddr_sel=1. On mem_ready: cu_irwrite=1 in that same cycle, then -> DECODE.
  - DECODE: cu_immtype, cu_alusrc and cu_wbsel are registered from opcode and held until the next DECODE.
  - DECODE opcode mapping:
    - 0110011 R: alusrc=0, wbsel=00
    - 0010011 OP-IMM: I, alusrc=1, wbsel=00
    - 0000011 LOAD: I, alusrc=1, wbsel=01
    - 1100111 JALR: I, alusrc=1, wbsel=10
    - 0100011 STORE: S, alusrc=1
    - 1100011 BRANCH: B, alusrc=0
    - 0110111 LUI: U, wbsel=11
    - 0010111 AUIPC: U, alusrc=1, wbsel=00
    - 1101111 JAL: J, wbsel=10
    - Any other opcode -> TRAP with cause 01.
  - EXEC: LOAD/STORE -> MEM. BRANCH: cu_pcwrite=1 and cu_branch=1 for one cycle, then -> FETCH. All other opcodes -> WB.
  - MEM: cu_iaddr_sel=0. LOAD holds cu_memread=1 until mem_ready, then -> WB. STORE holds cu_memwrite=1 until mem_ready; on the ready cycle cu_pcwrite=1, then -> FETCH.
  - WB: cu_regwrite=1 and cu_pcwrite=1 for exactly one cycle, then -> FETCH.
  - TRAP: all strobes 0. The state is held until reset; cu_trap=1 and cu_cause is frozen.
- Handshake:
  - A request stays asserted and stable until the cycle mem_ready=1. Completion happens in that cycle; no extra cycle is added.
  - mem_ready outside FETCH/MEM is ignored.
  - mem_ready already high on entry completes in the first cycle.
- Watchdog:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments on each cycle without mem_ready.
  - If the counter reaches MEM_TIMEOUT-1 and mem_ready is still 0 -> TRAP with cause 10 (FETCH) or 11 (MEM).
  - mem_ready in the same cycle as the timeout wins; no trap is taken.
- Latency in cycles with zero-wait memory: R/I/U/JAL/JALR = 4, LOAD = 5, STORE = 4, BRANCH = 3.
- Mutual exclusion: cu_memread and cu_memwrite are never asserted together. cu_regwrite and cu_pcwrite are never asserted outside WB, except cu_pcwrite as specified for BRANCH and STORE.
- Reset mid-operation: takes effect immediately regardless of state, drops all requests, and restarts via IDLE.

Decomposition:
- Shared package rv32_ctrl_pkg holds:
  - opcode constants (OPC_LOAD, OPC_STORE, ...)
  - IMM_I/S/B/U/J 3-bit codes, matching the immediate selector encoding
  - WB_ALU/MEM/PC4/IMM codes
  - state encodings
  - cause codes
- One sub-module: rv32_opdecode, purely combinational. It maps opcode to {immtype, alusrc, wbsel, class, illegal}. The FSM instantiates it and registers its outputs in DECODE.

Test Plan:
- Reset then ADDI (0010011), mem_ready always 1 -> states 0,1,2,3,5,1. cu_immtype=000, alusrc=1, wbsel=00. regwrite and pcwrite pulse together in WB, 4 cycles per instruction.
- LW with mem_ready low for 3 cycles in MEM -> cu_memread held for 4 cycles, then WB with wbsel=01. Total 8 cycles from FETCH entry.
- SW then BEQ -> immtype 001, then immtype 010. STORE pcwrite coincides with mem_ready and memwrite. BRANCH gives one cycle with pcwrite=1 and branch=1 in EXEC, and regwrite is never 1.
- LUI, JAL, AUIPC -> immtype 011 with wbsel 11; 100 with wbsel 10; 011 with wbsel 00 and alusrc=1.
- Opcode 1111111 -> TRAP after DECODE with cu_trap=1 and cu_cause=01. The state is held for 20 cycles; reset restores IDLE and clears cause.
- MEM_TIMEOUT=4, mem_ready=0 during FETCH -> TRAP after 4 cycles with cause 10. Repeat with mem_ready=1 on the 4th cycle -> no trap, DECODE entered.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control unit. It holds the
// opcode constants, the immediate-format codes (these match the immediate
// selector's encoding), the writeback source codes, the FSM state encoding,
// the fault cause codes and the coarse instruction classes used for
// sequencing.
package rv32_ctrl_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Writeback sources
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_ILLEGAL   = 2'b01,
    CAUSE_FETCH_TMO = 2'b10,
    CAUSE_DATA_TMO  = 2'b11
  } cause_t;

  // Sequencing class: decides the path taken after EXEC
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

endpackage

// File: rtl/rv32_opdecode.sv
// rv32_opdecode
// Purely combinational opcode decoder for the multi-cycle controller.
// Ports:
//   opcode   in  7  instr[6:0]
//   immtype  out 3  immediate format code
//   alusrc   out 1  ALU operand B select (1 = immediate)
//   wbsel    out 2  writeback source
//   op_class out 2  sequencing class (ALU/LOAD/STORE/BRANCH)
//   illegal  out 1  opcode is not one of the supported RV32I majors
module rv32_opdecode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] immtype,
  output logic       alusrc,
  output logic [1:0] wbsel,
  output op_class_t  op_class,
  output logic       illegal
);

  // Fields that an opcode does not care about stay at I-format, rs2, ALU
  always_comb begin
    immtype  = IMM_I;
    alusrc   = 1'b0;
    wbsel    = WB_ALU;
    op_class = CLS_ALU;
    illegal  = 1'b0;
    case (opcode)
      OPC_R: begin
      end
      OPC_OPIMM: begin
        alusrc = 1'b1;
      end
      OPC_LOAD: begin
        alusrc   = 1'b1;
        wbsel    = WB_MEM;
        op_class = CLS_LOAD;
      end
      OPC_JALR: begin
        alusrc = 1'b1;
        wbsel  = WB_PC4;
      end
      OPC_STORE: begin
        immtype  = IMM_S;
        alusrc   = 1'b1;
        op_class = CLS_STORE;
      end
      OPC_BRANCH: begin
        immtype  = IMM_B;
        op_class = CLS_BRANCH;
      end
      OPC_LUI: begin
        immtype = IMM_U;
        wbsel   = WB_IMM;
      end
      OPC_AUIPC: begin
        immtype = IMM_U;
        alusrc  = 1'b1;
      end
      OPC_JAL: begin
        immtype = IMM_J;
        wbsel   = WB_PC4;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_rv32i.sv
// multicycle_ctrl_rv32i
// Moore-style multi-cycle control unit for the RV32I core. It sequences
// FETCH, DECODE, EXEC, MEM and WB, and generates the datapath strobes.
// Memory requests wait on a ready handshake guarded by a watchdog. Illegal
// opcodes and memory timeouts park the unit in TRAP until reset.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   opcode[6:0]  in   instruction register opcode field
//   mem_ready    in   memory completes the current request this cycle
//   cu_state     out  current FSM state (debug)
//   cu_pcwrite, cu_irwrite, cu_branch, cu_regwrite   out  datapath strobes
//   cu_memread, cu_memwrite, cu_iaddr_sel            out  memory interface
//   cu_immtype, cu_alusrc, cu_wbsel   out  registered decode fields
//   cu_trap, cu_cause                 out  sticky fault status
module multicycle_ctrl_rv32i
  import rv32_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] cu_state,
  output logic       cu_pcwrite,
  output logic       cu_irwrite,
  output logic [2:0] cu_immtype,
  output logic       cu_alusrc,
  output logic [1:0] cu_wbsel,
  output logic       cu_branch,
  output logic       cu_regwrite,
  output logic       cu_memread,
  output logic       cu_memwrite,
  output logic       cu_iaddr_sel,
  output logic       cu_trap,
  output logic [1:0] cu_cause
);

  state_t     state, state_next;
  cause_t     cause_q, cause_next;
  logic [7:0] wait_cnt;
  logic [2:0] imm_q;
  logic       alusrc_q;
  logic [1:0] wbsel_q;
  op_class_t  class_q;

  logic [2:0] dec_immtype;
  logic       dec_alusrc;
  logic [1:0] dec_wbsel;
  op_class_t  dec_class;
  logic       dec_illegal;
  logic       timeout;

  rv32_opdecode u_opdecode (
    .opcode   (opcode),
    .immtype  (dec_immtype),
    .alusrc   (dec_alusrc),
    .wbsel    (dec_wbsel),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  // A ready in the final allowed cycle still completes, so the timeout
  // only fires when the counter has reached its limit and ready is low.
  assign timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1)) && !mem_ready;

  // State, cause, wait counter and the decode fields latched in DECODE.
  // The counter restarts on any state change, so it is zero on entry to
  // FETCH or MEM, and counts only the cycles spent waiting for ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= 8'd0;
      imm_q    <= IMM_I;
      alusrc_q <= 1'b0;
      wbsel_q  <= WB_ALU;
      class_q  <= CLS_ALU;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state) begin
        wait_cnt <= 8'd0;
      end else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == ST_DECODE && !dec_illegal) begin
        imm_q    <= dec_immtype;
        alusrc_q <= dec_alusrc;
        wbsel_q  <= dec_wbsel;
        class_q  <= dec_class;
      end
    end
  end

  // Next-state and strobe generation. Strobes default low; the irwrite and
  // the store pcwrite depend on mem_ready so completion needs no extra cycle.
  always_comb begin
    state_next   = state;
    cause_next   = cause_q;
    cu_pcwrite   = 1'b0;
    cu_irwrite   = 1'b0;
    cu_branch    = 1'b0;
    cu_regwrite  = 1'b0;
    cu_memread   = 1'b0;
    cu_memwrite  = 1'b0;
    cu_iaddr_sel = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        cu_memread   = 1'b1;
        cu_iaddr_sel = 1'b1;
        if (mem_ready) begin
          cu_irwrite = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_FETCH_TMO;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_BRANCH: begin
            cu_pcwrite = 1'b1;
            cu_branch  = 1'b1;
            state_next = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (class_q == CLS_STORE) begin
          cu_memwrite = 1'b1;
        end else begin
          cu_memread = 1'b1;
        end
        if (mem_ready) begin
          if (class_q == CLS_STORE) begin
            cu_pcwrite = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_DATA_TMO;
        end
      end
      ST_WB: begin
        cu_regwrite = 1'b1;
        cu_pcwrite  = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cu_state   = state;
  assign cu_immtype = imm_q;
  assign cu_alusrc  = alusrc_q;
  assign cu_wbsel   = wbsel_q;
  assign cu_trap    = (state == ST_TRAP);
  assign cu_cause   = cause_q;

endmodule
